// File: rtl/datapath_if.sv
// Control/data bundle for the single-bus datapath.
//   master : sequencer side, drives the memory data, selects, enables and ALU ops,
//            and observes the bus, R1 and MAR
//   slave  : datapath side
interface datapath_if;
  logic [31:0] MDatain;
  logic        Read;
  // bus source selects
  logic PCout, Zhighout, Zlowout, MDRout, R2out, R3out, HIout, LOout, InPortout, Cout;
  // register load enables
  logic R1in, R2in, R3in, PCin, IRin, MARin, MDRin, Yin, Zin;
  // ALU op selects
  logic IncPC, ROR;
  // observation
  logic [31:0] BusMuxOut, R1q, MARq;

  modport master (
    output MDatain, Read,
    output PCout, Zhighout, Zlowout, MDRout, R2out, R3out, HIout, LOout, InPortout, Cout,
    output R1in, R2in, R3in, PCin, IRin, MARin, MDRin, Yin, Zin,
    output IncPC, ROR,
    input  BusMuxOut, R1q, MARq
  );

  modport slave (
    input  MDatain, Read,
    input  PCout, Zhighout, Zlowout, MDRout, R2out, R3out, HIout, LOout, InPortout, Cout,
    input  R1in, R2in, R3in, PCin, IRin, MARin, MDRin, Yin, Zin,
    input  IncPC, ROR,
    output BusMuxOut, R1q, MARq
  );
endinterface

// File: rtl/datapath.sv
// Single-bus CPU datapath: register file slice, priority bus mux, and an
// ALU producing a 64-bit Z (INC / ROR / ADD). Sequencing is fully external.
//   clk : rising-edge clock
//   clr : asynchronous active-low clear of every register
//   bus : datapath_if.slave (memory data, selects, enables, ALU ops, observation)
module datapath (
  input  logic        clk,
  input  logic        clr,
  datapath_if.slave   bus
);
  logic [31:0] r1_q, r1_d, r2_q, r2_d, r3_q, r3_d, pc_q, pc_d, ir_q, ir_d;
  logic [31:0] mar_q, mar_d, mdr_q, mdr_d, y_q, y_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d, inport_q, inport_d;
  logic [63:0] z_q, z_d;
  logic [31:0] bus_mux, c_sext, alu_lo;
  logic [63:0] rot_dbl;
  logic        unused_ir;

  // Immediate field of IR, sign-extended from bit 18.
  assign c_sext    = {{13{ir_q[18]}}, ir_q[18:0]};
  assign unused_ir = ^ir_q[31:19];

  // Priority bus: first asserted select wins, idle bus reads 0.
  always_comb begin
    bus_mux = 32'h0;
    if      (bus.PCout)     bus_mux = pc_q;
    else if (bus.Zhighout)  bus_mux = z_q[63:32];
    else if (bus.Zlowout)   bus_mux = z_q[31:0];
    else if (bus.MDRout)    bus_mux = mdr_q;
    else if (bus.R2out)     bus_mux = r2_q;
    else if (bus.R3out)     bus_mux = r3_q;
    else if (bus.HIout)     bus_mux = hi_q;
    else if (bus.LOout)     bus_mux = lo_q;
    else if (bus.InPortout) bus_mux = inport_q;
    else if (bus.Cout)      bus_mux = c_sext;
  end

  // Rotate right via a doubled word so an amount of 0 needs no special case.
  assign rot_dbl = {y_q, y_q} >> bus_mux[4:0];

  always_comb begin
    alu_lo = y_q + bus_mux;
    if      (bus.IncPC) alu_lo = bus_mux + 32'd1;
    else if (bus.ROR)   alu_lo = rot_dbl[31:0];
  end

  always_comb begin
    r1_d     = bus.R1in  ? bus_mux : r1_q;
    r2_d     = bus.R2in  ? bus_mux : r2_q;
    r3_d     = bus.R3in  ? bus_mux : r3_q;
    pc_d     = bus.PCin  ? bus_mux : pc_q;
    ir_d     = bus.IRin  ? bus_mux : ir_q;
    mar_d    = bus.MARin ? bus_mux : mar_q;
    y_d      = bus.Yin   ? bus_mux : y_q;
    mdr_d    = mdr_q;
    if (bus.MDRin) mdr_d = bus.Read ? bus.MDatain : bus_mux;
    z_d      = bus.Zin   ? {32'h0, alu_lo} : z_q;
    // No load path: these sit at their cleared value.
    hi_d     = hi_q;
    lo_d     = lo_q;
    inport_d = inport_q;
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r1_q <= '0; r2_q <= '0; r3_q <= '0; pc_q <= '0; ir_q <= '0;
      mar_q <= '0; mdr_q <= '0; y_q <= '0; z_q <= '0;
      hi_q <= '0; lo_q <= '0; inport_q <= '0;
    end else begin
      r1_q <= r1_d; r2_q <= r2_d; r3_q <= r3_d; pc_q <= pc_d; ir_q <= ir_d;
      mar_q <= mar_d; mdr_q <= mdr_d; y_q <= y_d; z_q <= z_d;
      hi_q <= hi_d; lo_q <= lo_d; inport_q <= inport_d;
    end
  end

  assign bus.BusMuxOut = bus_mux;
  assign bus.R1q       = r1_q;
  assign bus.MARq      = mar_q;
endmodule

// File: tb/tb_datapath.sv
module tb_datapath;
  logic clk = 1'b0;
  logic clr = 1'b0;
  always #5 clk = ~clk;

  datapath_if dif ();
  datapath u_dut (.clk(clk), .clr(clr), .bus(dif));

  // control flag bits
  localparam int PCO=0, ZHO=1, ZLO=2, MDO=3, R2O=4, R3O=5, HIO=6, LOO=7, INO=8, CO=9;
  localparam int R1I=10, R2I=11, R3I=12, PCI=13, IRI=14, MARI=15, MDRI=16, YI=17, ZI=18;
  localparam int INC=19, RORB=20, RD=21;

  typedef struct packed { logic [21:0] f; logic [31:0] md; } ctrl_t;
  typedef struct { ctrl_t c; logic [31:0] bus, r1, mar; } vec_t;

  int ncmp = 0, nerr = 0;

  // behavioural model state
  logic [31:0] m_r1, m_r2, m_r3, m_pc, m_ir, m_mar, m_mdr, m_y;
  logic [63:0] m_z;

  function automatic logic [21:0] fl(input int a, input int b = -1, input int c = -1,
                                     input int d = -1, input int e = -1);
    logic [21:0] v = '0;
    if (a >= 0) v[a] = 1'b1;
    if (b >= 0) v[b] = 1'b1;
    if (c >= 0) v[c] = 1'b1;
    if (d >= 0) v[d] = 1'b1;
    if (e >= 0) v[e] = 1'b1;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input ctrl_t c);
    dif.PCout = c.f[PCO]; dif.Zhighout = c.f[ZHO]; dif.Zlowout = c.f[ZLO];
    dif.MDRout = c.f[MDO]; dif.R2out = c.f[R2O]; dif.R3out = c.f[R3O];
    dif.HIout = c.f[HIO]; dif.LOout = c.f[LOO]; dif.InPortout = c.f[INO]; dif.Cout = c.f[CO];
    dif.R1in = c.f[R1I]; dif.R2in = c.f[R2I]; dif.R3in = c.f[R3I]; dif.PCin = c.f[PCI];
    dif.IRin = c.f[IRI]; dif.MARin = c.f[MARI]; dif.MDRin = c.f[MDRI]; dif.Yin = c.f[YI];
    dif.Zin = c.f[ZI]; dif.IncPC = c.f[INC]; dif.ROR = c.f[RORB]; dif.Read = c.f[RD];
    dif.MDatain = c.md;
  endtask

  function automatic void m_clear();
    m_r1 = 0; m_r2 = 0; m_r3 = 0; m_pc = 0; m_ir = 0; m_mar = 0; m_mdr = 0; m_y = 0; m_z = 0;
  endfunction

  // Bus value: walk sources in priority order; HI/LO/InPort are always 0.
  function automatic logic [31:0] m_bus(input ctrl_t c);
    logic [31:0] src [10];
    src = '{m_pc, m_z[63:32], m_z[31:0], m_mdr, m_r2, m_r3, 32'h0, 32'h0, 32'h0,
            32'($signed(m_ir[18:0]))};
    for (int i = 0; i < 10; i++) if (c.f[i]) return src[i];
    return 32'h0;
  endfunction

  function automatic void m_edge(input ctrl_t c);
    logic [31:0] b, v;
    b = m_bus(c);
    v = m_y;
    for (int k = 0; k < int'(b[4:0]); k++) v = {v[0], v[31:1]};
    if (c.f[ZI]) m_z = {32'h0, c.f[INC] ? b + 1 : (c.f[RORB] ? v : m_y + b)};
    if (c.f[R1I])  m_r1  = b;
    if (c.f[R2I])  m_r2  = b;
    if (c.f[R3I])  m_r3  = b;
    if (c.f[PCI])  m_pc  = b;
    if (c.f[IRI])  m_ir  = b;
    if (c.f[MARI]) m_mar = b;
    if (c.f[YI])   m_y   = b;
    if (c.f[MDRI]) m_mdr = c.f[RD] ? c.md : b;
  endfunction

  vec_t tbl [$];
  task automatic add(input logic [21:0] f, input logic [31:0] md, input logic [31:0] b,
                     input logic [31:0] r1, input logic [31:0] mar);
    vec_t v;
    v.c.f = f; v.c.md = md; v.bus = b; v.r1 = r1; v.mar = mar;
    tbl.push_back(v);
  endtask

  ctrl_t c;
  ctrl_t idle;

  initial begin
    idle = '0;
    drive(idle);
    // directed sequences from reset
    add(fl(RD, MDRI),           32'hDD,       32'h0,        0,            0);
    add(fl(MDO, R2I),           0,            32'hDD,       0,            0);
    add(fl(R2O),                0,            32'hDD,       0,            0);
    add(fl(PCO, MARI, INC, ZI), 0,            32'h0,        0,            0);
    add(fl(ZLO, PCI),           0,            32'h1,        0,            0);
    add(fl(PCO),                0,            32'h1,        0,            0);
    add(fl(ZHO),                0,            32'h0,        0,            0);
    add(fl(RD, MDRI),           32'h4,        32'h0,        0,            0);
    add(fl(MDO, R3I),           0,            32'h4,        0,            0);
    add(fl(R2O, YI),            0,            32'hDD,       0,            0);
    add(fl(R3O, RORB, ZI),      0,            32'h4,        0,            0);
    add(fl(ZLO, R1I),           0,            32'hD000000D, 32'hD000000D, 0);
    add(fl(RORB, ZI),           0,            32'h0,        32'hD000000D, 0);
    add(fl(ZLO, R1I),           0,            32'hDD,       32'hDD,       0);
    add(fl(RD, MDRI),           32'h0007FFFF, 32'h0,        32'hDD,       0);
    add(fl(MDO, IRI),           0,            32'h0007FFFF, 32'hDD,       0);
    add(fl(CO),                 0,            32'hFFFFFFFF, 32'hDD,       0);
    add(fl(PCO, MDO),           0,            32'h1,        32'hDD,       0);
    add(fl(R3O, ZI),            0,            32'h4,        32'hDD,       0);
    add(fl(ZLO),                0,            32'hE1,       32'hDD,       0);
    add(fl(R2O, INC, RORB, ZI), 0,            32'hDD,       32'hDD,       0);
    add(fl(ZLO, MARI),          0,            32'hDE,       32'hDD,       32'hDE);
    add(fl(RD, MDRI),           32'h1F,       32'h0,        32'hDD,       32'hDE);
    add(fl(MDO, RORB, ZI),      0,            32'h1F,       32'hDD,       32'hDE);
    add(fl(ZLO),                0,            32'h1BA,      32'hDD,       32'hDE);
    add(fl(CO, YI),             0,            32'hFFFFFFFF, 32'hDD,       32'hDE);
    add(fl(PCO, ZI),            0,            32'h1,        32'hDD,       32'hDE);
    add(fl(ZLO),                0,            32'h0,        32'hDD,       32'hDE);
    add(fl(ZHO),                0,            32'h0,        32'hDD,       32'hDE);
    add(fl(MDO, MDRI, RD),      32'h55,       32'h1F,       32'hDD,       32'hDE);
    add(fl(MDO),                0,            32'h55,       32'hDD,       32'hDE);

    // reset state
    #1;
    check("rst_bus", dif.BusMuxOut, 32'h0);
    check("rst_r1", dif.R1q, 32'h0);
    check("rst_mar", dif.MARq, 32'h0);
    c = idle; c.f = fl(PCO); drive(c); #1;
    check("rst_pc", dif.BusMuxOut, 32'h0);
    drive(idle);
    #2 clr = 1'b1;
    @(posedge clk); #1;

    // table-driven directed vectors
    foreach (tbl[i]) begin
      drive(tbl[i].c); #1;
      check($sformatf("vec%0d_bus", i), dif.BusMuxOut, tbl[i].bus);
      @(posedge clk); #1;
      check($sformatf("vec%0d_r1", i), dif.R1q, tbl[i].r1);
      check($sformatf("vec%0d_mar", i), dif.MARq, tbl[i].mar);
    end

    // clear between edges: everything drops at once
    drive(idle); #1;
    clr = 1'b0; #1;
    check("clr_r1", dif.R1q, 32'h0);
    check("clr_mar", dif.MARq, 32'h0);
    for (int i = 0; i < 10; i++) begin
      c = idle; c.f[i] = 1'b1; drive(c); #0.1;
      check($sformatf("clr_src%0d", i), dif.BusMuxOut, 32'h0);
    end
    // enable held across an edge while clear is low, then across release
    c = idle; c.f = fl(MDO, MDRI, RD, R1I); c.md = 32'h77; drive(c);
    @(posedge clk); #1;
    check("clr_hold_bus", dif.BusMuxOut, 32'h0);
    check("clr_hold_r1", dif.R1q, 32'h0);
    #2 clr = 1'b1; #1;
    check("rel_pre_bus", dif.BusMuxOut, 32'h0);
    @(posedge clk); #1;
    check("rel_load_mdr", dif.BusMuxOut, 32'h77);
    check("rel_r1_old_bus", dif.R1q, 32'h0);

    // randomized vs model
    m_clear(); m_mdr = 32'h77;
    for (int n = 0; n < 400; n++) begin
      c = idle;
      for (int i = 0; i < 10; i++) c.f[i] = ($urandom_range(5) == 0);
      for (int i = 10; i < 22; i++) c.f[i] = ($urandom_range(2) == 0);
      c.md = ($urandom_range(1) == 0) ? 32'($urandom_range(63)) : $urandom;
      drive(c);
      if ($urandom_range(39) == 0) begin
        clr = 1'b0; #1;
        m_clear();
        check("rnd_clr_bus", dif.BusMuxOut, m_bus(c));
        @(posedge clk); #1;
        check("rnd_clr_r1", dif.R1q, m_r1);
        clr = 1'b1;
      end else begin
        #1;
        check("rnd_bus", dif.BusMuxOut, m_bus(c));
        @(posedge clk);
        m_edge(c);
        #1;
        check("rnd_r1", dif.R1q, m_r1);
        check("rnd_mar", dif.MARq, m_mar);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
